posit_norm_adjust: RTL
======================

POSIT_NORM_ADJUST -- requirements
Module: posit_norm_adjust

Interface
REQ-001 SHALL have parameter PROD_W, default 64: mantissa-product width, format 2.(PROD_W-2).
REQ-002 SHALL have parameter SCALE_W, default 10: signed scale width.
REQ-003 SHALL have parameter ES, default 3: posit exponent field width.
REQ-004 SHALL have parameter NBITS, default 32: target posit width; RUN_W = clog2(NBITS)+1 and SH_W = clog2(PROD_W).
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request, sampled only in IDLE.
REQ-008 SHALL have port scale_in, input, SCALE_W: signed scale of the product.
REQ-009 SHALL have port mant_prod, input, PROD_W: unsigned mantissa product.
REQ-010 SHALL have ports busy (1), done (1), zero (1), sat (1), sticky (1), exp_sign (1): all outputs.
REQ-011 SHALL have output mant_adj (PROD_W): normalised mantissa, hidden bit at [PROD_W-2].
REQ-012 SHALL have outputs scale_out (SCALE_W, signed), shift_amt (SH_W: left-shift count), adj_regime (RUN_W: regime run length), adj_exp (ES).

Function
REQ-013 SHALL implement FSM IDLE, CHECK, NORM, DECOMP, DONE; busy = (state != IDLE && state != DONE).
REQ-014 In IDLE with start=1, SHALL capture mant_prod and sign-extended scale_in into SCALE_W+1-bit internal scale, clear shift_amt/sticky/sat/zero, go CHECK.
REQ-015 SHALL ignore start outside IDLE; captured operands are not disturbed.
REQ-016 CHECK: mant==0 -> DONE with zero=1, mant_adj=0, scale_out=0, adj_regime=0, adj_exp=0, exp_sign=0.
REQ-017 CHECK: bit[PROD_W-1]=1 -> mant shifted right 1, sticky=dropped LSB, scale+1, go DECOMP.
REQ-018 CHECK: bits[PROD_W-1:PROD_W-2]=01 -> no change, go DECOMP.
REQ-019 CHECK: top two bits 00 (nonzero) -> go NORM.
REQ-020 NORM: each cycle with bit[PROD_W-2]=0, SHALL shift left 1, scale-1, shift_amt+1; with bit set, go DECOMP.
REQ-021 DECOMP: SHALL clamp scale to +/-(NBITS-2)*2^ES (default +/-240) and set sat=1 if clamping occurred.
REQ-022 DECOMP: k = clamped scale arithmetically shifted right by ES; adj_exp = scale[ES-1:0]; exp_sign = scale sign bit.
REQ-023 DECOMP: adj_regime = k+1 for k>=0, -k for k<0; scale_out = clamped scale truncated to SCALE_W.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; all result outputs held until next accepted start.
REQ-025 Latency, counted from the edge sampling start: done high after edge 2 for zero/right-shift/no-shift cases; after edge L+3 for L left shifts.
REQ-026 A start asserted during the DONE cycle SHALL be ignored; the block accepts it on the following IDLE cycle.

Reset
REQ-027 reset=1 SHALL force IDLE immediately and zero every output, including during NORM; no done follows.
REQ-028 After reset deassertion, the first start in IDLE SHALL run normally.

Verification
REQ-029 scale_in=100, mant=C000...0 -> mant_adj=6000...0, scale_out=101, shift_amt=0, adj_regime=13, adj_exp=5, sticky=0, done after edge 2.
REQ-030 scale_in=100, mant=4000...0 -> unchanged mant, scale_out=100, adj_regime=13, adj_exp=4; mant=8000...0 -> 4000...0, scale_out=101.
REQ-031 scale_in=100, mant=00F0...0 -> L=7, mant_adj=7800...0, scale_out=93, shift_amt=7, adj_regime=12, adj_exp=5, done after edge 10.
REQ-032 scale_in=239, mant=8000...01 -> scale_out=240, sticky=1, sat=0; scale_in=-511, mant=1 -> shift_amt=62, scale_out=-240, sat=1, exp_sign=1, adj_regime=30, adj_exp=0, done after edge 65.
REQ-033 mant=0 -> zero=1 and all fields 0 after edge 2; start pulsed while busy -> no second done and result unchanged.
REQ-034 reset pulsed mid-NORM -> outputs 0, busy=0, no done; a subsequent request completes correctly.

Source files
------------

// File: rtl/posit_norm_adjust.sv
// posit_norm_adjust: normalises a 2.(PROD_W-2) mantissa product so that the
// hidden bit sits at [PROD_W-2], tracks the matching scale, then splits the
// clamped scale into a posit regime run length and exponent field.
// The regime/exponent split is evaluated combinationally on the edge that
// leaves CHECK or NORM with a normalised mantissa, so the decomposition costs
// no extra cycle: results and done appear together on entry to DONE. The
// DECOMP encoding performs the same split from the held registers if entered.
module posit_norm_adjust #(
  parameter int  PROD_W  = 64,
  parameter int  SCALE_W = 10,
  parameter int  ES      = 3,
  parameter int  NBITS   = 32,
  localparam int RUN_W   = $clog2(NBITS) + 1,
  localparam int SH_W    = $clog2(PROD_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [SCALE_W-1:0] scale_in,
  input  logic [PROD_W-1:0]         mant_prod,
  output logic                      busy,
  output logic                      done,
  output logic                      zero,
  output logic                      sat,
  output logic                      sticky,
  output logic                      exp_sign,
  output logic [PROD_W-1:0]         mant_adj,
  output logic signed [SCALE_W-1:0] scale_out,
  output logic [SH_W-1:0]           shift_amt,
  output logic [RUN_W-1:0]          adj_regime,
  output logic [ES-1:0]             adj_exp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] NORM   = 3'd2;
  localparam logic [2:0] DECOMP = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // Internal scale carries one guard bit so shifting never wraps before clamping.
  localparam logic signed [SCALE_W:0] SCALE_MAX = (SCALE_W+1)'((NBITS - 2) << ES);
  localparam logic signed [SCALE_W:0] SCALE_MIN = -SCALE_MAX;
  localparam logic signed [SCALE_W:0] SCALE_ONE = (SCALE_W+1)'(1'b1);
  localparam logic [SH_W-1:0]         SH_ONE    = SH_W'(1'b1);

  logic [2:0]                state_r, state_n;
  logic [PROD_W-1:0]         mant_r, mant_n;
  logic signed [SCALE_W:0]   scale_r, scale_n;
  logic [SH_W-1:0]           shift_r, shift_n;
  logic                      sticky_r, sticky_n;
  logic                      clear_s, zero_hit_s, decomp_s;

  logic signed [SCALE_W:0]   clamp_s, k_s;
  logic                      clip_s;
  logic [RUN_W-1:0]          regime_s;

  logic                      busy_r, done_r, zero_r, sat_r, esign_r;
  logic signed [SCALE_W-1:0] scale_out_r;
  logic [RUN_W-1:0]          regime_r;
  logic [ES-1:0]             exp_r;

  // Next-state and datapath step for the normalisation sequencer.
  always_comb begin
    state_n    = state_r;
    mant_n     = mant_r;
    scale_n    = scale_r;
    shift_n    = shift_r;
    sticky_n   = sticky_r;
    clear_s    = 1'b0;
    zero_hit_s = 1'b0;
    decomp_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mant_n   = mant_prod;
          scale_n  = {scale_in[SCALE_W-1], scale_in};
          shift_n  = '0;
          sticky_n = 1'b0;
          clear_s  = 1'b1;
          state_n  = CHECK;
        end else begin
          state_n = IDLE;
        end
      end
      CHECK: begin
        if (mant_r == '0) begin
          zero_hit_s = 1'b1;
          state_n    = DONE;
        end else if (mant_r[PROD_W-1]) begin
          // Product in [2,4): one right shift, remember the dropped bit.
          mant_n   = {1'b0, mant_r[PROD_W-1:1]};
          sticky_n = mant_r[0];
          scale_n  = scale_r + SCALE_ONE;
          decomp_s = 1'b1;
          state_n  = DONE;
        end else if (mant_r[PROD_W-2]) begin
          decomp_s = 1'b1;
          state_n  = DONE;
        end else begin
          state_n = NORM;
        end
      end
      NORM: begin
        if (mant_r[PROD_W-2]) begin
          decomp_s = 1'b1;
          state_n  = DONE;
        end else begin
          mant_n  = {mant_r[PROD_W-2:0], 1'b0};
          scale_n = scale_r - SCALE_ONE;
          shift_n = shift_r + SH_ONE;
        end
      end
      DECOMP: begin
        decomp_s = 1'b1;
        state_n  = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Clamp the final scale and split it into regime run length and exponent.
  always_comb begin
    if (scale_n > SCALE_MAX) begin
      clamp_s = SCALE_MAX;
      clip_s  = 1'b1;
    end else if (scale_n < SCALE_MIN) begin
      clamp_s = SCALE_MIN;
      clip_s  = 1'b1;
    end else begin
      clamp_s = scale_n;
      clip_s  = 1'b0;
    end
    k_s = clamp_s >>> ES;
    if (k_s[SCALE_W]) begin
      regime_s = RUN_W'(-k_s);
    end else begin
      regime_s = RUN_W'(k_s + SCALE_ONE);
    end
  end

  // State, working operands and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      mant_r      <= '0;
      scale_r     <= '0;
      shift_r     <= '0;
      sticky_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      zero_r      <= 1'b0;
      sat_r       <= 1'b0;
      esign_r     <= 1'b0;
      scale_out_r <= '0;
      regime_r    <= '0;
      exp_r       <= '0;
    end else begin
      state_r  <= state_n;
      mant_r   <= mant_n;
      scale_r  <= scale_n;
      shift_r  <= shift_n;
      sticky_r <= sticky_n;
      busy_r   <= (state_n != IDLE) && (state_n != DONE);
      done_r   <= (state_n == DONE);
      if (clear_s) begin
        zero_r <= 1'b0;
        sat_r  <= 1'b0;
      end else if (zero_hit_s) begin
        zero_r      <= 1'b1;
        sat_r       <= 1'b0;
        esign_r     <= 1'b0;
        scale_out_r <= '0;
        regime_r    <= '0;
        exp_r       <= '0;
      end else if (decomp_s) begin
        sat_r       <= clip_s;
        esign_r     <= clamp_s[SCALE_W];
        scale_out_r <= clamp_s[SCALE_W-1:0];
        regime_r    <= regime_s;
        exp_r       <= clamp_s[ES-1:0];
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign zero       = zero_r;
  assign sat        = sat_r;
  assign sticky     = sticky_r;
  assign exp_sign   = esign_r;
  assign mant_adj   = mant_r;
  assign scale_out  = scale_out_r;
  assign shift_amt  = shift_r;
  assign adj_regime = regime_r;
  assign adj_exp    = exp_r;

endmodule
